interrupt_controller: RTL

- Fixed-priority interrupt controller in front of the CPU's 8-bit interrupt input.
- Captures edges on raw request lines and holds them as pending bits, masks them, and picks the highest-priority pending source.
- Presents one request at a time with an 8-bit vector.
- Sequences each interrupt through request, CPU acknowledge, in-service and return; software writes the mask register.

---
 rtl/intc_pkg.sv | 25 ++
 rtl/interrupt_controller_if.sv | 32 +++
 rtl/intc_prio_enc.sv | 25 ++
 rtl/interrupt_controller.sv | 136 +++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and helpers for the fixed-priority interrupt controller.
// Holds the FSM state type, vector defaults and vector arithmetic.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } intc_state_t;

  localparam logic [7:0] INTC_VEC_BASE = 8'h10;
  localparam int unsigned INTC_VEC_SHIFT = 2;

  // Vectors wrap modulo 256.
  function automatic logic [7:0] intc_vec(
    input logic [7:0]  base,
    input int unsigned shift,
    input int unsigned idx
  );
    logic [31:0] v;
    v = 32'(base) + (idx << shift);
    return v[7:0];
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-facing handshake and mask-write bundle of the interrupt controller.
// master = controller side, slave = CPU / software side.
interface interrupt_controller_if
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 8
);
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_in;
  logic               int_ack;
  logic               int_done;
  logic               int_req;
  logic [7:0]         int_vec;

  modport master (
    input  mask_we,
    input  mask_in,
    input  int_ack,
    input  int_done,
    output int_req,
    output int_vec
  );

  modport slave (
    output mask_we,
    output mask_in,
    output int_ack,
    output int_done,
    input  int_req,
    input  int_vec
  );
endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-set-bit encoder: index 0 has the highest priority.
// Purely combinational; valid is low when no bit is set.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  cand,
  output logic [IW-1:0] sel,
  output logic          valid
);

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel   = IW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: edge capture, mask, request FSM.
// Define INTC_NESTING_EN to allow preemption with an in-service stack.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int          NUM_IRQ   = 8,
  parameter logic [7:0]  VEC_BASE  = INTC_VEC_BASE,
  parameter int unsigned VEC_SHIFT = INTC_VEC_SHIFT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  interrupt_controller_if.master bus,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  intc_state_t        state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] clr;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      cur;
  logic [IW-1:0]      enc_sel;
  logic               enc_valid;
  logic               req_q;
  logic [7:0]         vec_q;
  logic               ack;
  logic               preempt;
  logic               take;

  assign rise = irq & ~irq_q;
  assign cand = pending & ~mask;
  assign ack  = (state == REQUEST) && bus.int_ack;

  intc_prio_enc #(
    .N  (NUM_IRQ),
    .IW (IW)
  ) u_enc (
    .cand  (cand),
    .sel   (enc_sel),
    .valid (enc_valid)
  );

`ifdef INTC_NESTING_EN
  localparam int SW = $clog2(NUM_IRQ + 1);

  logic [IW-1:0] stk [2**SW];
  logic [SW-1:0] sp;

  // cur is always the lowest in-service index while nested.
  assign preempt = enc_valid && (enc_sel < cur);
`else
  assign preempt = 1'b0;
`endif

  assign take =
    ((state == IDLE) && enc_valid) ||
    ((state == SERVICE) && !bus.int_done && preempt);

  always_comb begin
    clr = '0;
    if (ack) clr[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '1;
      in_service <= '0;
      req_q      <= 1'b0;
      vec_q      <= '0;
      sel        <= '0;
      cur        <= '0;
      state      <= IDLE;
`ifdef INTC_NESTING_EN
      sp         <= '0;
`endif
    end else begin
      irq_q   <= irq;
      // New edge wins over a same-cycle acknowledge clear.
      pending <= (pending & ~clr) | rise;
      if (bus.mask_we) mask <= bus.mask_in;

      unique case (state)
        IDLE: ;
        REQUEST: begin
          if (bus.int_ack) begin
            req_q           <= 1'b0;
            in_service[sel] <= 1'b1;
            cur             <= sel;
            state           <= SERVICE;
`ifdef INTC_NESTING_EN
            if (|in_service) begin
              stk[sp] <= cur;
              sp      <= sp + 1'b1;
            end
`endif
          end
        end
        SERVICE: begin
          if (bus.int_done) begin
            in_service[cur] <= 1'b0;
`ifdef INTC_NESTING_EN
            if (sp != '0) begin
              cur <= stk[sp - 1'b1];
              sp  <= sp - 1'b1;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      if (take) begin
        sel   <= enc_sel;
        vec_q <= intc_vec(VEC_BASE, VEC_SHIFT, 32'(enc_sel));
        req_q <= 1'b1;
        state <= REQUEST;
      end
    end
  end

  assign bus.int_req = req_q;
  assign bus.int_vec = vec_q;

endmodule
